// File: rtl/sram_arbiter.sv
// sram_arbiter
// Two-requester round-robin arbiter and access sequencer in front of one
// sram_core host interface. Accepts one transaction at a time, holds the
// core's enable/rnw/addr/data_in stable until the core reports ready (or a
// cycle timeout expires), returns read data or an error, then waits for the
// core to drop ready before accepting the next request.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req[1:0]             per-port request level (sampled only when idle)
//   rnw0/1, addr0/1,     per-port operation (1 = read), address, write data
//   wdata0/1
//   gnt[1:0]             one-hot pulse: request of port i accepted
//   done[1:0]            one-hot pulse: transaction of port i finished
//   err                  pulse with done: the transaction timed out
//   rdata                read data, valid with done on a read
//   busy                 high whenever the arbiter is not idle
//   mem_enable, mem_rnw, to sram_core enable / read_not_write / addr / data_in
//   mem_addr, mem_wdata
//   mem_rdata, mem_ready from sram_core data_out / ready
module sram_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic              rnw0,
  input  logic              rnw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t           state_reg;
  logic             last_served_reg;
  logic             winner_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Port selected if we are idle and anyone is requesting. On a tie the
  // port that was not served last wins; otherwise the lone requester wins.
  logic pick;
  assign pick = (req == 2'b11) ? ~last_served_reg : req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      last_served_reg <= 1'b1;
      winner_reg      <= 1'b0;
      cnt_reg         <= '0;
      gnt             <= 2'b00;
      done            <= 2'b00;
      err             <= 1'b0;
      rdata           <= '0;
      busy            <= 1'b0;
      mem_enable      <= 1'b0;
      mem_rnw         <= 1'b1;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      // Pulses default low every cycle.
      gnt  <= 2'b00;
      done <= 2'b00;
      err  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            state_reg       <= ACCESS;
            busy            <= 1'b1;
            mem_enable      <= 1'b1;
            mem_rnw         <= pick ? rnw1   : rnw0;
            mem_addr        <= pick ? addr1  : addr0;
            mem_wdata       <= pick ? wdata1 : wdata0;
            gnt             <= pick ? 2'b10  : 2'b01;
            last_served_reg <= pick;
            winner_reg      <= pick;
            cnt_reg         <= '0;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            // Ready takes priority over a coinciding timeout.
            done       <= winner_reg ? 2'b10 : 2'b01;
            if (mem_rnw) begin
              rdata <= mem_rdata;
            end
            mem_enable <= 1'b0;
            state_reg  <= RECOVER;
          end else if (cnt_reg == CNT_LAST) begin
            done       <= winner_reg ? 2'b10 : 2'b01;
            err        <= 1'b1;
            rdata      <= '0;
            mem_enable <= 1'b0;
            state_reg  <= RECOVER;
          end else if (gnt == 2'b00) begin
            // The grant cycle itself is not counted, so an abort lands
            // TIMEOUT+1 cycles after gnt. The count stops at CNT_LAST, so
            // it never wraps.
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        RECOVER: begin
          // Wait for the core to drop ready so a stale ready is never
          // mistaken for completion of the next access.
          if (!mem_ready) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            mem_rnw   <= 1'b1;
          end
        end

        default: begin
          state_reg  <= IDLE;
          busy       <= 1'b0;
          mem_enable <= 1'b0;
          mem_rnw    <= 1'b1;
        end
      endcase
    end
  end

endmodule
